aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Round sequencer for the AES-128 datapath. Accepts one block per valid/ready handshake and
//  steps the round datapath (addroundkey, sub/shift/mix) through round 0..NR.
//  Drives roundnumber, round type and a one-cycle start strobe per round, then waits for step_done.
//  Sits between the block input/output handshakes and the round datapath plus expanded-key store.
// PARAMETERS
//  NR      10  number of full cipher rounds; legal 1..15 (roundnumber is 4 bits)
// PORTS
//  clk         in   1  clock, all state on rising edge
//  rst         in   1  asynchronous active-high reset
//  in_valid    in   1  input block available
//  in_ready    out  1  controller can accept a block (high only in IDLE with key_valid)
//  key_valid   in   1  expanded key store holds a valid 1408-bit schedule
//  load_state  out  1  one-cycle strobe: datapath captures input block into its state register
//  step_start  out  1  one-cycle strobe: datapath executes the round selected by roundnumber/round_type
//  roundnumber out  4  current round index, selects key[roundnumber*128 +: 128]
//  round_type  out  2  0 = ARK only (round 0), 1 = full round, 2 = final round (no mixcolumns)
//  step_done   in   1  datapath finished the step started by the last step_start
//  out_valid   out  1  result block valid at datapath output
//  out_ready   in   1  downstream accepts result
//  busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, load_state, step_start, out_valid, busy = 0; roundnumber=0; round_type=0.
//  FSM: IDLE -> LOAD -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//   IDLE : in_ready = key_valid. in_valid && in_ready -> LOAD; roundnumber<=0, round_type<=0.
//   LOAD : load_state=1 for this cycle only -> ISSUE.
//   ISSUE: step_start=1 for this cycle only -> WAIT.
//   WAIT : hold roundnumber/round_type until step_done. On step_done:
//          roundnumber==NR -> DONE; else roundnumber<=roundnumber+1,
//          round_type<= (roundnumber+1==NR) ? 2 : 1, -> ISSUE.
//   DONE : out_valid=1; hold until out_ready; then -> IDLE, roundnumber<=0, round_type<=0.
//  step_done outside WAIT is ignored; step_done in the same cycle as step_start is ignored.
//  Latency: with step_done returned 1 cycle after each step_start, handshake to out_valid =
//   2 + 2*(NR+1) cycles (24 for NR=10). Longer datapath latency extends WAIT only.
//  key_valid dropping mid-block does not abort; it only gates the next in_ready.
//  out_valid stays high and all outputs frozen while out_ready=0 (no data loss).
//  in_ready low throughout LOAD..DONE; back-to-back blocks start no earlier than the cycle after DONE exits.
//  roundnumber never exceeds NR; no wrap. Async rst mid-block returns to IDLE at once; block is dropped.
//  Strobe outputs are registered (decoded from next-state) so datapath sees glitch-free single pulses.
// CONFIGURATION
//  AES_DECRYPT_EN defined: adds input port decrypt (1 bit), sampled at the IDLE->LOAD handshake.
//   decrypt=1: roundnumber starts at NR and counts down to 0; round_type: NR -> 0 (ARK only),
//   1..NR-1 -> 1, 0 -> 2 (final); completion when roundnumber==0 in WAIT.
//   Latency identical to encrypt.
//  Not defined: no decrypt port; encrypt ordering only.
// TESTING
//  1 Reset: assert rst mid-WAIT at round 5 -> all outputs reset values same cycle, in_ready=key_valid after release.
//  2 Single block, NR=10, step_done 1 cycle after each step_start -> 11 step_start pulses,
//    roundnumber 0..10, round_type 0,1x9,2; out_valid on cycle 24 after handshake.
//  3 Backpressure: out_ready=0 for 7 cycles in DONE -> out_valid held, roundnumber=10, no new in_ready.
//  4 Slow datapath: step_done delayed 5 cycles, spurious step_done in IDLE -> ignored,
//    round count unchanged, out_valid after 2+6*11 cycles.
//  5 Key gating: key_valid=0 with in_valid=1 -> in_ready=0, no load_state;
//    raise key_valid -> handshake next cycle.
//  6 AES_DECRYPT_EN, decrypt=1 -> roundnumber 10..0, round_type 0,1x9,2, out_valid at cycle 24.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer: block handshake, per-round step strobes, result handshake.
// Optional AES_DECRYPT_EN adds a decrypt input that reverses the round order.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_valid,
  output logic       load_state,
  output logic       step_start,
  output logic [3:0] roundnumber,
  output logic [1:0] round_type,
  input  logic       step_done,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef AES_DECRYPT_EN
  input  logic       decrypt,
`endif
  output logic       busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] rn_q, rn_d;
  logic [1:0] rt_q, rt_d;
  logic       in_ready_q, in_ready_d;
  logic       load_state_q, load_state_d;
  logic       step_start_q, step_start_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
`ifdef AES_DECRYPT_EN
  logic       decrypt_q, decrypt_d;
`endif

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rt_d    = rt_q;
`ifdef AES_DECRYPT_EN
    decrypt_d = decrypt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_LOAD;
          rt_d    = 2'd0;
`ifdef AES_DECRYPT_EN
          decrypt_d = decrypt;
          rn_d      = decrypt ? NR_L : 4'd0;
`else
          rn_d      = 4'd0;
`endif
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // step_done is only honoured here, so strays in other states are dropped
        if (step_done) begin
`ifdef AES_DECRYPT_EN
          if (decrypt_q) begin
            if (rn_q == 4'd0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              rn_d    = rn_q - 4'd1;
              rt_d    = (rn_q == 4'd1) ? 2'd2 : 2'd1;
            end
          end else
`endif
          if (rn_q == NR_L) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            rn_d    = rn_q + 4'd1;
            rt_d    = ((rn_q + 4'd1) == NR_L) ? 2'd2 : 2'd1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          rn_d    = 4'd0;
          rt_d    = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs decoded from next state so every strobe leaves a flop
    in_ready_d   = (state_d == S_IDLE) && key_valid;
    load_state_d = (state_d == S_LOAD);
    step_start_d = (state_d == S_ISSUE);
    out_valid_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rn_q         <= 4'd0;
      rt_q         <= 2'd0;
      in_ready_q   <= 1'b0;
      load_state_q <= 1'b0;
      step_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef AES_DECRYPT_EN
      decrypt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rn_q         <= rn_d;
      rt_q         <= rt_d;
      in_ready_q   <= in_ready_d;
      load_state_q <= load_state_d;
      step_start_q <= step_start_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
`ifdef AES_DECRYPT_EN
      decrypt_q    <= decrypt_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign load_state  = load_state_q;
  assign step_start  = step_start_q;
  assign roundnumber = rn_q;
  assign round_type  = rt_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl with a round scoreboard.
module tb_aes_round_ctrl;
  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rst, in_valid, key_valid, out_ready, force_done, resp_done;
  logic       in_ready, load_state, step_start, out_valid, busy, step_done;
  logic [3:0] roundnumber;
  logic [1:0] round_type;
`ifdef AES_DECRYPT_EN
  logic       decrypt = 1'b0;
`endif

  int         total = 0, bad = 0, starts = 0, pend = 0, resp_dly = 1;
  logic [5:0] exp_q[$];
  logic [5:0] exp_e;

  assign step_done = resp_done | force_done;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_valid(key_valid), .load_state(load_state), .step_start(step_start),
    .roundnumber(roundnumber), .round_type(round_type), .step_done(step_done),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath model: answers each step_start after resp_dly cycles
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (rst) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) resp_done = 1'b1;
      end
      if (step_start) pend = resp_dly;
    end
  end

  always @(negedge clk) begin
    if (!rst && step_start) begin
      starts++;
      if (exp_q.size() == 0) chk("step_unexpected", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        chk("step_rn_rt", {26'd0, roundnumber, round_type}, {26'd0, exp_e});
      end
    end
  end

  task automatic push_enc();
    for (int k = 0; k <= NR; k++)
      exp_q.push_back({4'(k), (k == 0) ? 2'd0 : (k == NR) ? 2'd2 : 2'd1});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", in_ready, 1);
  endtask

  task automatic run_block(input int lat);
    int n;
    wait_ready();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    chk("load_strobe", load_state, 1);
    chk("busy_in_load", busy, 1);
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    chk("latency", n, lat);
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
    force_done = 1'b0; resp_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rn", roundnumber, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single block, fast datapath
    starts = 0;
    push_enc();
    run_block(2 + 2 * (NR + 1));
    chk("rn_at_done", roundnumber, NR);
    chk("step_count", starts, NR + 1);
    chk("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_exit_out_valid", out_valid, 0);
    chk("done_exit_busy", busy, 0);
    chk("done_exit_in_ready", in_ready, 1);

    // Backpressure in DONE
    out_ready = 1'b0;
    push_enc();
    run_block(2 + 2 * (NR + 1));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_rn", roundnumber, NR);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);

    // Slow datapath plus a stray step_done while idle
    s0 = starts;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_rn", roundnumber, 0);
    chk("stray_starts", starts, s0);
    resp_dly = 5;
    push_enc();
    run_block(2 + 6 * (NR + 1));
    chk("slow_steps", starts - s0, NR + 1);
    resp_dly = 1;
    @(negedge clk);

    // Key gating
    key_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("kg_in_ready", in_ready, 0);
      chk("kg_load", load_state, 0);
    end
    key_valid = 1'b1;
    @(negedge clk);
    chk("kg_ready_up", in_ready, 1);
    push_enc();
    @(negedge clk);
    in_valid = 1'b0;
    chk("kg_load_after", load_state, 1);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("kg_block_done", out_valid, 1);
    @(negedge clk);

    // Async reset in the middle of round 5
    push_enc();
    wait_ready();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(roundnumber == 4'd5 && busy && !step_start) && n < 200) begin @(negedge clk); n++; end
    chk("reach_round5", roundnumber, 5);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_vec", {in_ready, load_state, step_start, out_valid, busy, roundnumber, round_type}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);

`ifdef AES_DECRYPT_EN
    // Decrypt ordering
    decrypt = 1'b1;
    for (int k = NR; k >= 0; k--)
      exp_q.push_back({4'(k), (k == NR) ? 2'd0 : (k == 0) ? 2'd2 : 2'd1});
    run_block(2 + 2 * (NR + 1));
    chk("dec_rn_done", roundnumber, 0);
    chk("dec_sb_empty", exp_q.size(), 0);
    decrypt = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
